seg_msg_scroller: RTL and testbench
===================================

// Module: seg_msg_scroller
// PURPOSE
//  Generalised 7-seg message engine: drives NUM_DIGITS digit codes (num[*]) for the hex
//  decoders from a message table selected by sw[3:0]. Short messages are shown static.
//  Long messages scroll left with a blank gap and wrap around. sw[9] blinks the display.
//  Sits between board switches and the per-digit 7-seg decoders in the top level.
// PARAMETERS
//  NUM_DIGITS  6   number of digit outputs; num[NUM_DIGITS-1] is leftmost
//  DIGIT_W     32  width of each digit code (decoder input)
//  TICK_DIV    25_000_000  clk cycles per scroll tick; must be >= NUM_DIGITS+2 (assert)
//  DEBOUNCE    1_000_000   cycles sw[3:0] must be stable before acceptance (>=1)
//  GAP         2   blank positions appended before wrap when scrolling
//  BLINK_TICKS 1   scroll ticks per blink phase
// PORTS
//  clk        in   1                     system clock
//  rst        in   1                     synchronous, active-high reset
//  sw         in   10                    [3:0] message select, [9] blink enable, rest unused
//  num        out  NUM_DIGITS x DIGIT_W  digit codes, registered
//  scrolling  out  1                     1 while the current message is longer than NUM_DIGITS
//  frame_upd  out  1                     1-cycle pulse on the cycle a new frame commits
// BEHAVIOUR
//  Reset: every num = BLANK_CODE (10); scrolling=0, frame_upd=0; FSM=IDLE; offset=0;
//   blink_phase=0; tick prescaler=0; accepted select = INVALID, so the first stable sw loads.
//  Input path: sw 2-flop synchroniser; debounce counter restarts on any change of synced
//   sw[3:0]; held DEBOUNCE consecutive cycles and != accepted -> accept, offset=0, go FILL.
//   sw[9] is synchronised only, not debounced.
//  Message: len L (0..15) and chars c[0..L-1] from package table. Virtual string v = c
//   followed by GAP blanks, period P=L+GAP. If L<=NUM_DIGITS: static, left-aligned,
//   num[NUM_DIGITS-1-i]=c[i] for i<L, rest BLANK. If L>NUM_DIGITS: scrolling=1,
//   num[NUM_DIGITS-1-i]=v[(offset+i) mod P]. Unused selects: L=0, all blank.
//  FSM: IDLE -> FILL (after accept) -> COMMIT -> HOLD.
//   FILL: one digit per cycle into shadow buffer, idx 0..NUM_DIGITS-1 (NUM_DIGITS cycles);
//    mod P done by compare/subtract, no divider.
//   COMMIT: shadow -> disp_buf, frame_upd=1, scrolling updated, go HOLD.
//   HOLD: on tick and scrolling: offset = (offset==P-1)?0:offset+1, go FILL. Static: stay.
//  Output register: num <= (sw9_sync & blink_phase) ? all BLANK : disp_buf, every cycle;
//   num reflects a commit one cycle after frame_upd. No tearing: num never mixes frames.
//  Tick: prescaler counts 0..TICK_DIV-1, tick on wrap; free-running from reset.
//   blink_phase toggles every BLINK_TICKS ticks; forced 0 while sw9_sync=0.
//  Boundaries:
//   accept during FILL/COMMIT: abort, offset=0, restart FILL idx 0; disp_buf unchanged.
//   tick during FILL: latched as pending (max 1), served on entering HOLD.
//   L==NUM_DIGITS: static, no gap shown. L=0: blank frame still committed (frame_upd pulses).
//   same select re-accepted after bounce: ignored, no reload, offset kept.
//   rst mid-scroll: next cycle all outputs at reset values.
// STRUCTURE
//  Package seg_pkg: BLANK_CODE=10, MSG_MAX_LEN=15, msg_t {len, chars[15]},
//   MSG_TABLE[16] (entry 5 = 9,1,6,7,2,3; entry 6 = 0..9; others len 0), fsm state enum.
//  Sub-module seg_debounce (sync + stability counter, outputs accepted value + accept pulse).
//  Message lookup is a combinational single-read-port function of (select, index).
// TESTING  (bench params: NUM_DIGITS=6, TICK_DIV=16, DEBOUNCE=3, GAP=2, BLINK_TICKS=1)
//  1 rst held 3 cycles, sw=0 -> all num=10, scrolling=0; blank frame committed after
//    sync+debounce+fill; num stays all 10.
//  2 sw[3:0]=5 -> frame_upd after 2+3+6+1 cycles; next cycle num5..num0=9,1,6,7,2,3;
//    scrolling=0; no further frame_upd over 100 cycles.
//  3 sw[3:0]=6 -> num5..0 = 0,1,2,3,4,5, scrolling=1; per tick frame 1..6; offset 6 ->
//    6,7,8,9,10,10; offset 11 -> 10,0,1,2,3,4; offset 12 wraps to the first frame.
//  4 sw toggles 5<->6 every 2 cycles for 20 cycles, then holds 6 -> exactly one accept;
//    scrolling restarts at offset 0; change injected mid-FILL aborts without tearing.
//  5 sw[9]=1 on msg 5 -> num alternates all 10 / 9,1,6,7,2,3 every 16 cycles;
//    sw[9]=0 -> steady within 3 cycles.
//  6 rst asserted mid-scroll, msg 6 -> next cycle all num=10, frame_upd=0, scrolling=0;
//    after release the sequence repeats exactly as in test 3.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types, constants and message table for the 7-segment message engine.
package seg_pkg;

    localparam logic [3:0] BLANK_CODE  = 4'd10;
    localparam int         MSG_MAX_LEN = 15;

    typedef struct packed {
        logic [3:0]                   len;
        logic [MSG_MAX_LEN-1:0][3:0] chars;
    } msg_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_COMMIT,
        S_HOLD
    } state_t;

    function automatic msg_t msg_table(input logic [3:0] sel);
        msg_t m;
        m = '0;
        unique case (sel)
            4'd5: begin
                m.len      = 4'd6;
                m.chars[0] = 4'd9;
                m.chars[1] = 4'd1;
                m.chars[2] = 4'd6;
                m.chars[3] = 4'd7;
                m.chars[4] = 4'd2;
                m.chars[5] = 4'd3;
            end
            4'd6: begin
                m.len = 4'd10;
                for (int i = 0; i < 10; i++) begin
                    m.chars[i] = 4'(i);
                end
            end
            default: ;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] msg_len(input logic [3:0] sel);
        msg_t m;
        m = msg_table(sel);
        return m.len;
    endfunction

    // Single read port: positions past the message end read as blank.
    function automatic logic [3:0] msg_char(input logic [3:0] sel,
                                            input logic [7:0] idx);
        msg_t m;
        m = msg_table(sel);
        if (idx < 8'(m.len)) begin
            return m.chars[idx[3:0]];
        end
        return BLANK_CODE;
    endfunction

endpackage

// File: rtl/seg_debounce.sv
// Two-flop synchroniser plus stability counter for the message select;
// pulses accept when a new value has been stable long enough.
module seg_debounce
    import seg_pkg::*;
#(
    parameter int DEBOUNCE = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    output logic [3:0] sel,
    output logic       accept
);

    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  held;
    logic [31:0] cnt;
    logic [31:0] cnt_nx;
    logic        acc_vld;

    // Counter saturates so a stable, already-accepted value never refires.
    always_comb begin
        cnt_nx = '0;
        if (s2 != held) begin
            cnt_nx = 32'd1;
        end else if (cnt == 32'(DEBOUNCE)) begin
            cnt_nx = cnt;
        end else begin
            cnt_nx = cnt + 32'd1;
        end
        accept = (cnt_nx == 32'(DEBOUNCE)) && (!acc_vld || (s2 != sel));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            held    <= '0;
            cnt     <= '0;
            sel     <= '0;
            acc_vld <= 1'b0;
        end else begin
            s1   <= sw;
            s2   <= s1;
            held <= s2;
            cnt  <= cnt_nx;
            if (accept) begin
                sel     <= s2;
                acc_vld <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_msg_scroller.sv
// Message engine: builds frames digit by digit into a shadow buffer and
// commits them atomically; long messages scroll on a prescaled tick.
module seg_msg_scroller
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int DIGIT_W     = 32,
    parameter int TICK_DIV    = 25_000_000,
    parameter int DEBOUNCE    = 1_000_000,
    parameter int GAP         = 2,
    parameter int BLINK_TICKS = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [9:0]                         sw,
    output logic [NUM_DIGITS-1:0][DIGIT_W-1:0] num,
    output logic                               scrolling,
    output logic                               frame_upd
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [3:0]    sel;
    logic          accept;
    logic          sw9_s1;
    logic          sw9_sync;
    state_t        state;
    logic [IW-1:0] idx;
    logic [7:0]    offset;
    logic          pending;
    logic [3:0]    shadow [NUM_DIGITS];
    logic [3:0]    disp   [NUM_DIGITS];
    logic [31:0]   presc;
    logic [31:0]   bcnt;
    logic          tick;
    logic          blink_phase;
    logic [3:0]    len;
    logic          long_msg;
    logic [7:0]    per;
    logic [7:0]    sum;
    logic [7:0]    pos;
    logic [7:0]    rd_idx;
    logic [3:0]    digit;
    logic          unused_sw;

    assign unused_sw = ^sw[8:4];

    seg_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .sw     (sw[3:0]),
        .sel    (sel),
        .accept (accept)
    );

    // offset < per and idx < per, so one conditional subtract wraps.
    always_comb begin
        len      = msg_len(sel);
        long_msg = 8'(len) > 8'(NUM_DIGITS);
        per      = 8'(len) + 8'(GAP);
        sum      = offset + 8'(idx);
        pos      = (sum >= per) ? sum - per : sum;
        rd_idx   = long_msg ? pos : 8'(idx);
        digit    = msg_char(sel, rd_idx);
        tick     = presc == 32'(TICK_DIV - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            offset    <= '0;
            pending   <= 1'b0;
            scrolling <= 1'b0;
            frame_upd <= 1'b0;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                shadow[d] <= BLANK_CODE;
                disp[d]   <= BLANK_CODE;
            end
        end else begin
            frame_upd <= 1'b0;
            if (tick && state != S_HOLD) begin
                pending <= 1'b1;
            end
            if (accept) begin
                state   <= S_FILL;
                idx     <= '0;
                offset  <= '0;
                pending <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: ;
                    S_FILL: begin
                        shadow[idx] <= digit;
                        if (idx == IW'(NUM_DIGITS - 1)) begin
                            state <= S_COMMIT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    S_COMMIT: begin
                        disp      <= shadow;
                        frame_upd <= 1'b1;
                        scrolling <= long_msg;
                        state     <= S_HOLD;
                    end
                    S_HOLD: begin
                        if (tick || pending) begin
                            pending <= 1'b0;
                            if (scrolling) begin
                                offset <= (offset == per - 8'd1) ?
                                          8'd0 : offset + 8'd1;
                                idx    <= '0;
                                state  <= S_FILL;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc       <= '0;
            bcnt        <= '0;
            blink_phase <= 1'b0;
            sw9_s1      <= 1'b0;
            sw9_sync    <= 1'b0;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                num[d] <= DIGIT_W'(BLANK_CODE);
            end
        end else begin
            assert (TICK_DIV >= NUM_DIGITS + 2);
            presc    <= tick ? 32'd0 : presc + 32'd1;
            sw9_s1   <= sw[9];
            sw9_sync <= sw9_s1;
            if (!sw9_sync) begin
                blink_phase <= 1'b0;
                bcnt        <= '0;
            end else if (tick) begin
                if (bcnt == 32'(BLINK_TICKS - 1)) begin
                    bcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    bcnt <= bcnt + 32'd1;
                end
            end
            for (int d = 0; d < NUM_DIGITS; d++) begin
                num[NUM_DIGITS-1-d] <= (sw9_sync && blink_phase) ?
                                       DIGIT_W'(BLANK_CODE) :
                                       DIGIT_W'(disp[d]);
            end
        end
    end

endmodule

// File: tb/tb_seg_msg_scroller.sv
// Scoreboard bench for seg_msg_scroller: expected frames are queued by the
// stimulus and checked by a monitor one cycle after each frame_upd.
module tb_seg_msg_scroller;

    localparam int ND = 6;
    localparam int DW = 32;

    typedef logic [ND-1:0][DW-1:0] frame_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] sw;
    frame_t     num;
    logic       scrolling;
    logic       frame_upd;

    int     n_cmp = 0;
    int     n_bad = 0;
    frame_t exp_q[$];
    bit     strict = 1'b0;
    frame_t mon_e;

    always #5 clk = ~clk;

    seg_msg_scroller #(
        .NUM_DIGITS  (ND),
        .DIGIT_W     (DW),
        .TICK_DIV    (16),
        .DEBOUNCE    (3),
        .GAP         (2),
        .BLINK_TICKS (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .num       (num),
        .scrolling (scrolling),
        .frame_upd (frame_upd)
    );

    function automatic int mlen(int sel);
        if (sel == 5) return 6;
        if (sel == 6) return 10;
        return 0;
    endfunction

    function automatic int mchr(int sel, int p);
        int t5[6];
        t5 = '{9, 1, 6, 7, 2, 3};
        if (sel == 5) return t5[p];
        return p;
    endfunction

    // Reference frame: virtual string is message plus two blanks.
    function automatic frame_t frame_of(int sel, int off);
        frame_t f;
        int     l;
        int     per;
        int     p;
        int     c;
        l   = mlen(sel);
        per = l + 2;
        for (int i = 0; i < ND; i++) begin
            p = (l <= ND) ? i : (off + i) % per;
            c = (p < l) ? mchr(sel, p) : 10;
            f[ND-1-i] = DW'(c);
        end
        return f;
    endfunction

    task automatic chkf(string nm, frame_t got, frame_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic chki(string nm, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    task automatic timeout(string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout required event", nm);
    endtask

    task automatic wait_frame(string nm, int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (frame_upd === 1'b1) begin
                n = i;
                return;
            end
        end
        timeout(nm);
    endtask

    task automatic drain(string nm, int max);
        for (int i = 0; i < max; i++) begin
            if (exp_q.size() == 0) return;
            @(negedge clk);
        end
        timeout(nm);
        exp_q.delete();
    endtask

    task automatic push_scroll6();
        for (int o = 0; o < 12; o++) exp_q.push_back(frame_of(6, o));
        exp_q.push_back(frame_of(6, 0));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && frame_upd === 1'b1) begin
                @(negedge clk);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chkf("frame", num, mon_e);
                end else if (strict) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame: got %h required none",
                             num);
                end
            end
        end
    end

    initial begin
        int     n;
        int     nfu;
        bit     found;
        bit     bad;
        frame_t blank;
        blank = frame_of(0, 0);

        // 1: reset and first blank frame
        sw  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chkf("reset_num", num, blank);
        chki("reset_scrolling", int'(scrolling), 0);
        chki("reset_frame_upd", int'(frame_upd), 0);
        strict = 1'b1;
        exp_q.push_back(blank);
        rst = 1'b0;
        wait_frame("t1_frame", 30, n);
        drain("t1_drain", 5);
        chkf("t1_num_blank", num, blank);
        chki("t1_scrolling", int'(scrolling), 0);

        // 2: static message and commit latency
        exp_q.push_back(frame_of(5, 0));
        sw[3:0] = 4'd5;
        wait_frame("t2_frame", 40, n);
        chki("t2_latency", n, 12);
        drain("t2_drain", 5);
        chki("t2_scrolling", int'(scrolling), 0);
        nfu = 0;
        repeat (100) begin
            @(negedge clk);
            if (frame_upd === 1'b1) nfu++;
        end
        chki("t2_no_frames", nfu, 0);

        // 3: scrolling message with gap and wrap
        push_scroll6();
        sw[3:0] = 4'd6;
        drain("t3_drain", 300);
        chki("t3_scrolling", int'(scrolling), 1);
        strict = 1'b0;

        // 4: bounce, single accept, then abort mid-fill
        sw[3:0] = 4'd5;
        repeat (40) @(negedge clk);
        chkf("t4_static", num, frame_of(5, 0));
        chki("t4_static_scroll", int'(scrolling), 0);
        strict = 1'b1;
        for (int o = 0; o < 4; o++) exp_q.push_back(frame_of(6, o));
        for (int i = 0; i < 20; i++) begin
            sw[3:0] = ((i / 2) % 2 != 0) ? 4'd5 : 4'd6;
            @(negedge clk);
        end
        sw[3:0] = 4'd6;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (exp_q.size() == 1) found = 1'b1;
            else @(negedge clk);
        end
        if (!found) timeout("t4_frames");
        wait_frame("t4_frame3", 40, n);
        repeat (7) @(negedge clk);
        exp_q.push_back(frame_of(5, 0));
        sw[3:0] = 4'd5;
        repeat (6) @(negedge clk);
        chkf("t4_no_tear", num, frame_of(6, 3));
        drain("t4_drain", 40);
        chki("t4_abort_scroll", int'(scrolling), 0);

        // 5: blink
        sw[9] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (num === blank) found = 1'b1;
        end
        if (!found) timeout("t5_blank");
        repeat (8) @(negedge clk);
        chkf("t5_blank_a", num, blank);
        repeat (8) @(negedge clk);
        chkf("t5_msg_a", num, frame_of(5, 0));
        repeat (8) @(negedge clk);
        chkf("t5_msg_b", num, frame_of(5, 0));
        repeat (8) @(negedge clk);
        chkf("t5_blank_b", num, blank);
        sw[9] = 1'b0;
        repeat (3) @(negedge clk);
        chkf("t5_off", num, frame_of(5, 0));
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (num !== frame_of(5, 0)) bad = 1'b1;
        end
        chki("t5_steady", int'(bad), 0);

        // 6: reset mid-scroll, then the scroll sequence repeats
        strict  = 1'b0;
        sw[3:0] = 4'd6;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (scrolling === 1'b1) found = 1'b1;
        end
        if (!found) timeout("t6_scroll");
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chkf("t6_rst_num", num, blank);
        chki("t6_rst_frame_upd", int'(frame_upd), 0);
        chki("t6_rst_scrolling", int'(scrolling), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push_scroll6();
        strict = 1'b1;
        drain("t6_drain", 300);
        strict = 1'b0;
        chki("t6_scrolling", int'(scrolling), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
